formula_n_pipe_aware_fsm: RTL and testbench



---
 rtl/formula_n_pipe_aware_fsm_pkg.sv | 15 +
 rtl/formula_n_pipe_aware_fsm_if.sv | 43 ++++
 rtl/formula_n_pipe_aware_fsm.sv | 117 +++++++++++
 tb/tb_formula_n_pipe_aware_fsm.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/formula_n_pipe_aware_fsm_pkg.sv
// rtl/formula_n_pipe_aware_fsm_pkg.sv - shared types and sizing helper for the pipelined sum-of-isqrt FSM
package formula_n_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Sum of n results of w/2 bits each never exceeds this width.
    function automatic int res_width(input int n, input int w);
        return w / 2 + $clog2(n + 1);
    endfunction

endpackage

// File: rtl/formula_n_pipe_aware_fsm_if.sv
// rtl/formula_n_pipe_aware_fsm_if.sv - argument/result and isqrt bus; err present with FORMULA_N_ORPHAN_CHECK_EN
interface formula_n_pipe_aware_fsm_if
    import formula_n_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int W      = 32,
    parameter int RES_W  = res_width(N_ARGS, W)
);

    logic                  arg_vld;
    logic [N_ARGS*W-1:0]   args;
    logic                  arg_rdy;
    logic                  res_vld;
    logic [RES_W-1:0]      res;
    logic                  isqrt_x_vld;
    logic [W-1:0]          isqrt_x;
    logic                  isqrt_y_vld;
    logic [W/2-1:0]        isqrt_y;
`ifdef FORMULA_N_ORPHAN_CHECK_EN
    logic                  err;

    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x, err
    );

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x, err
    );
`else
    modport slave (
        input  arg_vld, args, isqrt_y_vld, isqrt_y,
        output arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );

    modport master (
        output arg_vld, args, isqrt_y_vld, isqrt_y,
        input  arg_rdy, res_vld, res, isqrt_x_vld, isqrt_x
    );
`endif

endinterface

// File: rtl/formula_n_pipe_aware_fsm.sv
// rtl/formula_n_pipe_aware_fsm.sv - sum of isqrt over N_ARGS args through a shared pipelined isqrt
// Optional orphan/early-result detection with FORMULA_N_ORPHAN_CHECK_EN.
module formula_n_pipe_aware_fsm
    import formula_n_pkg::*;
#(
    parameter int N_ARGS = 3,
    parameter int W      = 32,
    parameter int RES_W  = res_width(N_ARGS, W)
) (
    input  logic                       clk,
    input  logic                       rst,
    formula_n_pipe_aware_fsm_if.slave  bus
);

    localparam int            CW   = $clog2(N_ARGS + 1);
    localparam logic [CW-1:0] LAST = CW'(N_ARGS - 1);

    state_t              state, state_nxt;
    logic [N_ARGS*W-1:0] arg_q;
    logic [CW-1:0]       issue_cnt;
    logic [CW-1:0]       rcv_cnt;
    logic [RES_W-1:0]    acc;
    logic [RES_W-1:0]    res_q;
    logic                res_vld_q;
    logic                accept;
    logic                y_take;
    logic                last_rcv;
    logic [RES_W-1:0]    y_ext;

    assign y_ext    = RES_W'(bus.isqrt_y);
    assign y_take   = bus.isqrt_y_vld && (state != IDLE);
    assign last_rcv = y_take && (state == DRAIN) && (rcv_cnt == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // arg[0] goes out combinationally on acceptance so the pipe fills without a bubble.
    always_comb begin
        state_nxt       = state;
        accept          = 1'b0;
        bus.arg_rdy     = 1'b0;
        bus.isqrt_x_vld = 1'b0;
        bus.isqrt_x     = bus.args[W-1:0];
        case (state)
            IDLE: begin
                bus.arg_rdy = 1'b1;
                if (bus.arg_vld) begin
                    accept          = 1'b1;
                    bus.isqrt_x_vld = 1'b1;
                    state_nxt       = (N_ARGS > 1) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                bus.isqrt_x_vld = 1'b1;
                bus.isqrt_x     = arg_q[int'(issue_cnt)*W +: W];
                if (issue_cnt == LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (last_rcv) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arg_q     <= '0;
            issue_cnt <= '0;
            rcv_cnt   <= '0;
            acc       <= '0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= last_rcv;
            if (accept) begin
                arg_q     <= bus.args;
                acc       <= '0;
                issue_cnt <= CW'(1);
                rcv_cnt   <= '0;
            end else begin
                if (state == ISSUE) issue_cnt <= issue_cnt + CW'(1);
                if (y_take) begin
                    acc     <= acc + y_ext;
                    rcv_cnt <= rcv_cnt + CW'(1);
                end
                if (last_rcv) res_q <= acc + y_ext;
            end
        end
    end

    assign bus.res_vld = res_vld_q;
    assign bus.res     = res_q;

`ifdef FORMULA_N_ORPHAN_CHECK_EN
    logic err_q;
    logic err_evt;

    // Result j may arrive no earlier than one cycle after its issue, i.e. only once issue_cnt > j.
    assign err_evt = bus.isqrt_y_vld &&
                     ((state == IDLE) ||
                      (rcv_cnt >= CW'(N_ARGS)) ||
                      (rcv_cnt >= issue_cnt));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          err_q <= 1'b0;
        else if (err_evt) err_q <= 1'b1;
    end

    assign bus.err = err_q;

    orphan_result_chk: assert property (@(posedge clk) disable iff (rst) !err_evt)
        else $error("unexpected isqrt result");
`endif

endmodule

// File: tb/tb_formula_n_pipe_aware_fsm.sv
// tb/tb_formula_n_pipe_aware_fsm.sv - self-checking bench: vector table, corner sequences, random ops vs reference sum
module tb_formula_n_pipe_aware_fsm;
    import formula_n_pkg::*;

    localparam int N   = 3;
    localparam int W   = 32;
    localparam int L   = 4;
    localparam int RW  = res_width(N, W);
    localparam int RW1 = res_width(1, W);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    formula_n_pipe_aware_fsm_if #(.N_ARGS(N), .W(W), .RES_W(RW))  bus ();
    formula_n_pipe_aware_fsm_if #(.N_ARGS(1), .W(W), .RES_W(RW1)) sbus ();

    formula_n_pipe_aware_fsm #(.N_ARGS(N), .W(W), .RES_W(RW))  dut  (.clk(clk), .rst(rst), .bus(bus));
    formula_n_pipe_aware_fsm #(.N_ARGS(1), .W(W), .RES_W(RW1)) sdut (.clk(clk), .rst(rst), .bus(sbus));

    int checks = 0;
    int errors = 0;

    // External isqrt model: digit-by-digit square root.
    function automatic logic [15:0] isqrt_digit(input logic [31:0] x);
        logic [31:0] op, r, one;
        op = x; r = 0; one = 32'h4000_0000;
        while (one > op) one = one >> 2;
        while (one != 0) begin
            if (op >= r + one) begin
                op = op - (r + one);
                r  = (r >> 1) + one;
            end else begin
                r = r >> 1;
            end
            one = one >> 2;
        end
        return r[15:0];
    endfunction

    // Reference: largest s with s*s <= x, by bisection.
    function automatic longint ref_isqrt(input longint x);
        longint lo, hi, mid;
        lo = 0; hi = 65536;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else                hi = mid;
        end
        return lo;
    endfunction

    function automatic logic [N*W-1:0] pack3(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2);
        return {a2, a1, a0};
    endfunction

    logic [L-1:0] mv;
    logic [15:0]  md [L];
    logic         mf;
    logic [15:0]  mf_y;
    logic         sv;
    logic [15:0]  sd;
    logic         sf;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mv <= '0;
            for (int i = 0; i < L; i++) md[i] <= '0;
            sv <= 1'b0;
            sd <= '0;
        end else begin
            mv    <= {mv[L-2:0], bus.isqrt_x_vld};
            md[0] <= isqrt_digit(bus.isqrt_x);
            for (int i = 1; i < L; i++) md[i] <= md[i-1];
            sv    <= sbus.isqrt_x_vld;
            sd    <= isqrt_digit(sbus.isqrt_x);
        end
    end

    assign bus.isqrt_y_vld  = mv[L-1] | mf;
    assign bus.isqrt_y      = mf ? mf_y : md[L-1];
    assign sbus.isqrt_y_vld = sv | sf;
    assign sbus.isqrt_y     = sf ? 16'd77 : sd;

    int            xcnt = 0;
    logic [31:0]   xlog [$];
    always @(negedge clk) begin
        if (bus.isqrt_x_vld) begin
            xcnt++;
            xlog.push_back(bus.isqrt_x);
        end
    end

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    // Waits for res_vld starting at cycle first_c of the operation; checks latency and value.
    task automatic wait_res(input string nm, input longint exp, input int first_c);
        int c;
        for (c = first_c; c < 60; c++) begin
            @(negedge clk);
            if (bus.res_vld) break;
        end
        check({nm, "_latency"}, c, N + L);
        check({nm, "_res"}, bus.res, exp);
    endtask

    task automatic do_op(input logic [N*W-1:0] a, input longint exp, input string nm);
        @(posedge clk); #1;
        bus.args    = a;
        bus.arg_vld = 1'b1;
        @(negedge clk);
        check({nm, "_x0_vld"}, bus.isqrt_x_vld, 1);
        check({nm, "_x0"}, bus.isqrt_x, a[31:0]);
        @(posedge clk); #1;
        bus.arg_vld = 1'b0;
        wait_res(nm, exp, 1);
        @(negedge clk);
        check({nm, "_strobe_one_cycle"}, bus.res_vld, 0);
        check({nm, "_res_hold"}, bus.res, exp);
    endtask

    typedef struct {
        logic [31:0] a0, a1, a2;
        longint      exp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        #2_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [N*W-1:0] ra;
        longint         rexp;
        int             x0, c;

        vecs[0] = '{32'd16, 32'd25, 32'd36, 15};
        vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 196605};
        vecs[2] = '{32'd0, 32'd0, 32'd0, 0};
        vecs[3] = '{32'd1, 32'd4, 32'd9, 6};
        vecs[4] = '{32'd2, 32'd3, 32'd8, 4};
        vecs[5] = '{32'd99, 32'd120, 32'd143, 30};
        vecs[6] = '{32'd65536, 32'd1, 32'd0, 257};
        vecs[7] = '{32'd4, 32'd4, 32'd4, 6};

        bus.arg_vld = 1'b0; bus.args = '0;
        sbus.arg_vld = 1'b0; sbus.args = '0;
        mf = 1'b0; mf_y = '0; sf = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_arg_rdy", bus.arg_rdy, 1);
        check("rst_res_vld", bus.res_vld, 0);
        check("rst_res", bus.res, 0);
        check("rst_x_vld", bus.isqrt_x_vld, 0);
        check("rst_small_arg_rdy", sbus.arg_rdy, 1);

        for (int v = 0; v < 8; v++) begin
            xlog.delete();
            x0 = xcnt;
            do_op(pack3(vecs[v].a0, vecs[v].a1, vecs[v].a2), vecs[v].exp, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_x_pulses", v), xcnt - x0, 3);
            if (xlog.size() == 3) begin
                check($sformatf("vec%0d_x1", v), xlog[1], vecs[v].a1);
                check($sformatf("vec%0d_x2", v), xlog[2], vecs[v].a2);
            end
        end

`ifndef FORMULA_N_ORPHAN_CHECK_EN
        @(posedge clk); #1;
        mf = 1'b1; mf_y = 16'd500;
        @(posedge clk); #1;
        mf = 1'b0;
        do_op(pack3(32'd1, 32'd4, 32'd9), 6, "after_orphan");
`endif

        // Back-to-back: second set held valid, accepted on the res_vld cycle.
        @(posedge clk); #1;
        bus.args = pack3(32'd16, 32'd25, 32'd36); bus.arg_vld = 1'b1;
        @(posedge clk); #1;
        bus.args = pack3(32'd1, 32'd4, 32'd9);
        wait_res("b2b_first", 15, 1);
        check("b2b_arg_rdy", bus.arg_rdy, 1);
        check("b2b_x_vld", bus.isqrt_x_vld, 1);
        check("b2b_x", bus.isqrt_x, 1);
        @(posedge clk); #1;
        bus.arg_vld = 1'b0;
        wait_res("b2b_second", 6, 1);

        // Pulses during ISSUE and DRAIN are ignored.
        repeat (2) @(posedge clk);
        x0 = xcnt;
        #1;
        bus.args = pack3(32'd16, 32'd25, 32'd36); bus.arg_vld = 1'b1;
        @(posedge clk); #1;
        bus.args = pack3(32'd100, 32'd100, 32'd100);
        @(negedge clk);
        check("ign_issue_arg_rdy", bus.arg_rdy, 0);
        @(posedge clk); #1; bus.arg_vld = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; bus.arg_vld = 1'b1;
        @(negedge clk);
        check("ign_drain_arg_rdy", bus.arg_rdy, 0);
        @(posedge clk); #1; bus.arg_vld = 1'b0;
        wait_res("ignored", 15, 5);
        repeat (4) @(negedge clk);
        check("ign_x_pulses", xcnt - x0, 3);

        // Asynchronous reset in cycle 2 of an operation.
        @(posedge clk); #1;
        bus.args = pack3(32'd16, 32'd25, 32'd36); bus.arg_vld = 1'b1;
        @(posedge clk); #1; bus.arg_vld = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_arg_rdy", bus.arg_rdy, 1);
        check("midrst_res_vld", bus.res_vld, 0);
        check("midrst_x_vld", bus.isqrt_x_vld, 0);
        check("midrst_res", bus.res, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_op(pack3(32'd4, 32'd4, 32'd4), 6, "post_rst");

        // Random operations against the reference sum.
        for (int k = 0; k < 25; k++) begin
            logic [31:0] r [3];
            rexp = 0;
            for (int j = 0; j < 3; j++) begin
                case ($urandom_range(0, 3))
                    0:       r[j] = 32'hFFFF_FFFF;
                    1:       r[j] = $urandom_range(0, 300);
                    default: r[j] = $urandom;
                endcase
                rexp += ref_isqrt(longint'(r[j]));
            end
            ra = pack3(r[0], r[1], r[2]);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            do_op(ra, rexp, $sformatf("rand%0d", k));
        end

        // N_ARGS = 1 with isqrt latency 1.
        @(posedge clk); #1;
        sbus.args = 32'd49; sbus.arg_vld = 1'b1;
        @(negedge clk);
        check("n1_x_vld", sbus.isqrt_x_vld, 1);
        check("n1_x", sbus.isqrt_x, 49);
        @(posedge clk); #1;
        sbus.arg_vld = 1'b0;
        for (c = 1; c < 20; c++) begin
            @(negedge clk);
            if (sbus.res_vld) break;
        end
        check("n1_latency", c, 2);
        check("n1_res", sbus.res, 7);

        @(posedge clk); #1; sf = 1'b1;
        @(posedge clk); #1; sf = 1'b0;
`ifdef FORMULA_N_ORPHAN_CHECK_EN
        @(negedge clk);
        check("n1_err_set", sbus.err, 1);
        repeat (3) @(negedge clk);
        check("n1_err_sticky", sbus.err, 1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("n1_err_cleared", sbus.err, 0);
`else
        @(posedge clk); #1;
        sbus.args = 32'd100; sbus.arg_vld = 1'b1;
        @(posedge clk); #1;
        sbus.arg_vld = 1'b0;
        for (c = 1; c < 20; c++) begin
            @(negedge clk);
            if (sbus.res_vld) break;
        end
        check("n1_orphan_latency", c, 2);
        check("n1_orphan_res", sbus.res, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
